// File: rtl/uart_fifo_tx_engine.sv
// UART transmit engine that pulls bytes from a standard (non-FWFT) FIFO and
// serialises them LSB first with optional parity and one or two stop bits.
module uart_fifo_tx_engine #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       empty,
   output logic       rd_en,
   input  logic [7:0] dout,
   output logic       tx_serial_data,
   output logic       tx_busy,
   output logic       tx_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      PAR   = 3'd5,
      STOP  = 3'd6
   } state_t;

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic       ODD_PAR   = (PARITY == 1);

   state_t                state_reg;
   logic [DATA_BITS-1:0]  shift_reg;
   logic [2:0]            bit_cnt_reg;
   logic                  stop_cnt_reg;
   logic                  parity_reg;
   logic                  line_reg;
   logic                  dout_unused;

   // Upper FIFO bits are don't-care when the frame is narrower than a byte.
   assign dout_unused = ^dout;

   // rd_en and tx_done are decoded from registered state so the read lands in
   // the very first IDLE cycle after a frame and tx_done marks the ending tick.
   assign rd_en          = (state_reg == IDLE) && !empty && !rst;
   assign tx_done        = (state_reg == STOP) && (stop_cnt_reg == LAST_STOP) && tx_en && !rst;
   assign tx_busy        = (state_reg != IDLE);
   assign tx_serial_data = line_reg;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         parity_reg   <= 1'b0;
         line_reg     <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!empty) state_reg <= FETCH;
            end
            FETCH: begin
               // FIFO data becomes valid during this cycle; capture on entry to LOAD.
               shift_reg  <= dout[DATA_BITS-1:0];
               parity_reg <= (^dout[DATA_BITS-1:0]) ^ ODD_PAR;
               state_reg  <= LOAD;
            end
            LOAD: begin
               if (tx_en) begin
                  line_reg  <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (tx_en) begin
                  line_reg    <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_cnt_reg <= 3'd0;
                  state_reg   <= DATA;
               end
            end
            DATA: begin
               if (tx_en) begin
                  if (bit_cnt_reg == LAST_BIT) begin
                     stop_cnt_reg <= 1'b0;
                     if (PARITY != 0) begin
                        line_reg  <= parity_reg;
                        state_reg <= PAR;
                     end else begin
                        line_reg  <= 1'b1;
                        state_reg <= STOP;
                     end
                  end else begin
                     line_reg    <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  end
               end
            end
            PAR: begin
               if (tx_en) begin
                  line_reg     <= 1'b1;
                  stop_cnt_reg <= 1'b0;
                  state_reg    <= STOP;
               end
            end
            STOP: begin
               if (tx_en) begin
                  if (stop_cnt_reg == LAST_STOP) state_reg <= IDLE;
                  else                           stop_cnt_reg <= stop_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_tx_engine.sv
// Five engine instances with different frame formats share one FIFO model and
// baud tick; one instance at a time is fed, the idle ones must stay quiet.
module tb_uart_fifo_tx_engine;

   localparam int NI = 5;
   localparam int DB_T[NI]  = '{8, 8, 8, 8, 5};
   localparam int PAR_T[NI] = '{0, 2, 1, 0, 0};
   localparam int SB_T[NI]  = '{1, 1, 1, 2, 1};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tx_en = 1'b0;
   logic [NI-1:0] empty_v, rd_en_v, line_v, busy_v, done_v;
   logic [7:0]    dout_r = 8'h00;
   logic          fifo_empty = 1'b1;
   logic [7:0]    fifo_q[$];
   int            fifo_n;
   int            active = -1;
   int            tick_period = 16;
   int            div = 0;
   int            checks = 0;
   int            failures = 0;
   int            idle_viol = 0;
   int            rd_cnt[NI];
   int            done_cnt[NI];
   int            pushed[NI];
   int            framed[NI];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         assign empty_v[gi] = (active == gi) ? fifo_empty : 1'b1;
         uart_fifo_tx_engine #(
            .DATA_BITS(DB_T[gi]),
            .PARITY   (PAR_T[gi]),
            .STOP_BITS(SB_T[gi])
         ) u_dut (
            .clk_in        (clk),
            .rst           (rst),
            .tx_en         (tx_en),
            .empty         (empty_v[gi]),
            .rd_en         (rd_en_v[gi]),
            .dout          (dout_r),
            .tx_serial_data(line_v[gi]),
            .tx_busy       (busy_v[gi]),
            .tx_done       (done_v[gi])
         );
      end
   endgenerate

   // Baud tick: one clock-wide pulse every tick_period clocks.
   always @(posedge clk) begin
      if (div >= tick_period - 1) begin
         div   <= 0;
         tx_en <= 1'b1;
      end else begin
         div   <= div + 1;
         tx_en <= 1'b0;
      end
   end

   // Standard FIFO: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      fifo_n = fifo_q.size();
      if (active >= 0 && fifo_n != 0) begin
         if (rd_en_v[active] === 1'b1) begin
            dout_r <= fifo_q.pop_front();
            fifo_n = fifo_n - 1;
         end
      end
      fifo_empty <= (fifo_n == 0);
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rd_en_v[k] === 1'b1) rd_cnt[k]++;
         if (done_v[k] === 1'b1) done_cnt[k]++;
         if (k != active && (rd_en_v[k] !== 1'b0 || line_v[k] !== 1'b1 ||
                             busy_v[k] !== 1'b0 || done_v[k] !== 1'b0))
            idle_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_active(input int k, input int p);
      @(negedge clk);
      active      = k;
      tick_period = p;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      pushed[active]++;
   endtask

   // Returns at the negedge of the first start-bit cycle.
   task automatic wait_start(input int k);
      int c;
      bit go;
      c = 0;
      while (rd_en_v[k] !== 1'b1 && c < 500) begin
         @(negedge clk);
         c++;
      end
      chk("rd_en_seen", {31'd0, rd_en_v[k]}, 32'd1);
      c  = 0;
      go = 1'b0;
      // Start bit follows the first tick seen at least two cycles after the read.
      while (!go && c < 4 * tick_period + 8) begin
         chk("line_before_start", {31'd0, line_v[k]}, 32'd1);
         if (c > 0) chk("rd_en_single", {31'd0, rd_en_v[k]}, 32'd0);
         if (c >= 2 && tx_en === 1'b1) go = 1'b1;
         @(negedge clk);
         c++;
      end
      chk("start_found", {31'd0, go}, 32'd1);
   endtask

   task automatic send_body(input int k, input logic [7:0] b, input bit more);
      int bits[$];
      int ones;
      int p;
      int bad;
      p    = tick_period;
      ones = 0;
      bits.push_back(0);
      for (int i = 0; i < DB_T[k]; i++) begin
         bits.push_back(int'(b[i]));
         ones += int'(b[i]);
      end
      if (PAR_T[k] == 2) bits.push_back(ones % 2);
      if (PAR_T[k] == 1) bits.push_back(1 - ones % 2);
      for (int s = 0; s < SB_T[k]; s++) bits.push_back(1);
      for (int i = 0; i < bits.size(); i++) begin
         bad = 0;
         for (int j = 0; j < p; j++) begin
            if (line_v[k] !== 1'(bits[i])) bad++;
            if (busy_v[k] !== 1'b1) bad++;
            if (rd_en_v[k] !== 1'b0) bad++;
            if (done_v[k] !== ((i == bits.size() - 1) && (j == p - 1))) bad++;
            @(negedge clk);
         end
         chk($sformatf("inst%0d_byte%02h_bit%0d_want%0d_bad_cycles", k, b, i, bits[i]), bad, 0);
      end
      chk("post_busy", {31'd0, busy_v[k]}, 32'd0);
      chk("post_line", {31'd0, line_v[k]}, 32'd1);
      chk("post_done", {31'd0, done_v[k]}, 32'd0);
      chk("post_rd_en", {31'd0, rd_en_v[k]}, {31'd0, more});
      framed[k]++;
      $display("frame inst=%0d byte=%02h bits=%0d period=%0d more=%0d", k, b, bits.size(), p, more);
   endtask

   task automatic run_frame(input int k, input logic [7:0] b, input bit more);
      wait_start(k);
      send_body(k, b, more);
   endtask

   initial begin
      logic [7:0] rb[$];
      int nf;
      int k;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_line%0d", i), {31'd0, line_v[i]}, 32'd1);
         chk($sformatf("reset_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
         chk($sformatf("reset_done%0d", i), {31'd0, done_v[i]}, 32'd0);
         chk($sformatf("reset_rd_en%0d", i), {31'd0, rd_en_v[i]}, 32'd0);
      end
      rst = 1'b0;

      // Empty FIFO everywhere with ticks running: nothing may happen.
      repeat (200) @(negedge clk);
      chk("idle_quiet", idle_viol, 0);

      set_active(0, 16);
      push(8'h55);
      run_frame(0, 8'h55, 1'b0);

      push(8'h01); push(8'hFF); push(8'h00);
      run_frame(0, 8'h01, 1'b1);
      run_frame(0, 8'hFF, 1'b1);
      run_frame(0, 8'h00, 1'b0);

      set_active(1, 16); push(8'hA3); run_frame(1, 8'hA3, 1'b0);
      set_active(2, 16); push(8'hA3); run_frame(2, 8'hA3, 1'b0);
      set_active(3, 16); push(8'h00); run_frame(3, 8'h00, 1'b0);
      set_active(4, 16); push(8'hFF); run_frame(4, 8'hFF, 1'b0);

      // Abort a frame in data bit 3, then confirm the next byte goes out whole.
      set_active(0, 16);
      push(8'hC6);
      wait_start(0);
      repeat (4 * 16 + 8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_line", {31'd0, line_v[0]}, 32'd1);
      chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      chk("abort_done", {31'd0, done_v[0]}, 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_reread", {31'd0, rd_en_v[0]}, 32'd0);
      push(8'h3C);
      run_frame(0, 8'h3C, 1'b0);

      // Random bytes and tick spacing (period 1 puts ticks on rd_en and FETCH).
      for (int r = 0; r < 8; r++) begin
         k = r % NI;
         set_active(k, (r == 0) ? 1 : int'($urandom_range(1, 20)));
         nf = int'($urandom_range(1, 4));
         rb.delete();
         for (int f = 0; f < nf; f++) begin
            rb.push_back(8'($urandom));
            push(rb[f]);
         end
         for (int f = 0; f < nf; f++) run_frame(k, rb[f], f < nf - 1);
         repeat (int'($urandom_range(0, 30))) @(negedge clk);
      end

      set_active(-1, 16);
      repeat (50) @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rd_count%0d", i), rd_cnt[i], pushed[i]);
         chk($sformatf("done_count%0d", i), done_cnt[i], framed[i]);
      end
      chk("idle_violations", idle_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
